pl_sysref_gen: RTL

//  PL-side SYSREF transmitter: produces a SYSREF pulse train on pl_clk for the RF-DAC/RF-ADC

---
 rtl/pl_sysref_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pl_sysref_gen.sv
// PL-side SYSREF pulse generator: burst or continuous pulse train with programmable
// period and high time, registered glitch-free output and runt-free stop.
module pl_sysref_gen #(
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 8
) (
  input  logic                pl_clk,
  input  logic                pl_rst,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_high,
  input  logic                cfg_mode,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic                arm,
  input  logic                stop,
  output logic                sysref_out,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [CNT_W-1:0]    pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] phase, phase_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                sysref_next;
  logic                done_next;
  logic                err_next;
  logic                load_cfg;

  logic [PERIOD_W-1:0] sh_period;
  logic [PERIOD_W-1:0] sh_high;
  logic                sh_mode;
  logic [CNT_W-1:0]    sh_count;

  logic                cfg_bad;
  logic                pulse_end;
  logic                burst_last;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    count_eff;

  assign cfg_bad   = (cfg_period < PERIOD_W'(2)) || (cfg_high == '0) ||
                     (cfg_high >= cfg_period);
  assign pulse_end = (phase == sh_high - PERIOD_W'(1));
  assign cnt_inc   = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + CNT_W'(1);
  assign count_eff = (sh_count == '0) ? CNT_W'(1) : sh_count;
  // The final pulse keeps its full high time; done coincides with its last high cycle.
  assign burst_last = !sh_mode && (cnt_inc == count_eff);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    phase_next  = phase;
    cnt_next    = pulse_cnt;
    sysref_next = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    load_cfg    = 1'b0;

    unique case (state)
      IDLE: begin
        if (arm) begin
          if (cfg_bad) begin
            err_next = 1'b1;
          end else begin
            load_cfg   = 1'b1;
            state_next = RUN;
            phase_next = '0;
            cnt_next   = '0;
          end
        end
      end

      RUN, STOPPING: begin
        sysref_next = (phase < sh_high);
        phase_next  = (phase == sh_period - PERIOD_W'(1)) ? '0 : phase + PERIOD_W'(1);
        if (pulse_end) cnt_next = cnt_inc;

        if (state == RUN) begin
          if (pulse_end && burst_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (stop && (pulse_end || (phase >= sh_high))) begin
            // Stop on the last high cycle or while low ends cleanly right away.
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (stop) begin
            state_next = STOPPING;
          end
        end else if (pulse_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end

        if (state_next == IDLE) phase_next = '0;
      end

      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      state      <= IDLE;
      phase      <= '0;
      sysref_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      sysref_out <= sysref_next;
      busy       <= (state_next != IDLE);
      done       <= done_next;
      cfg_err    <= err_next;
      pulse_cnt  <= cnt_next;
    end
  end

  // NOTE: shadow config is plain data only read outside IDLE, so it carries no reset.
  always_ff @(posedge pl_clk) begin
    if (load_cfg) begin
      sh_period <= cfg_period;
      sh_high   <= cfg_high;
      sh_mode   <= cfg_mode;
      sh_count  <= cfg_count;
    end
  end

endmodule
